holy_axil_regbank: RTL

Parametrised AXI-Lite slave register bank, the successor to the single-purpose AXI-Lite slave state machine used by the SoC peripherals. It exposes `NUM_REGS` memory-mapped registers, each `DATA_WIDTH` bits wide, with byte strobes, per-register read-only protection, and a hardware-side update port. Error responses are returned for bad accesses. It sits behind the SoC AXI-Lite interconnect and serves as the control/status block for core-side peripherals (timers, GPIO, debug).

---
 rtl/holy_axil_regbank.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/holy_axil_regbank.sv
// AXI-Lite slave register bank: NUM_REGS byte-strobed registers with read-only
// protection, error responses and a hardware-side update port.
module holy_axil_regbank #(
    parameter int                  NUM_REGS   = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    input  logic [NUM_REGS-1:0]            hw_wr_en,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wr_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // axi_state_slave_t encoding
    localparam logic [1:0] IDLE                      = 2'd0;
    localparam logic [1:0] LITE_RECEIVING_WRITE_DATA = 2'd1;
    localparam logic [1:0] LITE_SENDING_WRITE_RES    = 2'd2;
    localparam logic [1:0] LITE_SENDING_READ_DATA    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_fire, w_fire, ar_fire;
    logic [ADDR_WIDTH-1:0] wr_idx, ar_idx;
    logic [1:0]            wr_resp, ar_resp;
    logic [DATA_WIDTH-1:0] ar_data;

    // Out-of-range beats misalignment, which beats read-only protection.
    function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr,
                                               input logic                  is_write);
        logic [ADDR_WIDTH-1:0] idx;
        logic                  ro;
        idx = addr >> OFF;
        ro  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == ADDR_WIDTH'(i)) ro = RO_MASK[i];
        if (idx >= ADDR_WIDTH'(NUM_REGS)) return RESP_DECERR;
        if (addr[OFF-1:0] != '0)          return RESP_SLVERR;
        if (is_write && ro)               return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    assign s_awready = !rst && (state_q == IDLE);
    assign s_arready = !rst && (state_q == IDLE) && !s_awvalid;
    assign s_wready  = !rst && (state_q == LITE_RECEIVING_WRITE_DATA);
    assign s_bvalid  = (state_q == LITE_SENDING_WRITE_RES);
    assign s_rvalid  = (state_q == LITE_SENDING_READ_DATA);
    assign s_bresp   = bresp_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;
    assign ar_fire = s_arvalid && s_arready;
    assign wr_idx  = awaddr_q >> OFF;
    assign ar_idx  = s_araddr >> OFF;
    assign wr_resp = decode_resp(awaddr_q, 1'b1);
    assign ar_resp = decode_resp(s_araddr, 1'b0);

    always_comb begin
        ar_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ar_idx == ADDR_WIDTH'(i) && ar_resp == RESP_OKAY) ar_data = regs_q[i];
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        bresp_d  = bresp_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (aw_fire) begin
                    awaddr_d = s_awaddr;
                    state_d  = LITE_RECEIVING_WRITE_DATA;
                end else if (ar_fire) begin
                    rresp_d = ar_resp;
                    rdata_d = ar_data;
                    state_d = LITE_SENDING_READ_DATA;
                end
            end
            LITE_RECEIVING_WRITE_DATA: begin
                if (w_fire) begin
                    bresp_d = wr_resp;
                    state_d = LITE_SENDING_WRITE_RES;
                end
            end
            LITE_SENDING_WRITE_RES: if (s_bready) state_d = IDLE;
            LITE_SENDING_READ_DATA: if (s_rready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Hardware data lands first; strobed bus bytes then overlay it on a collision.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = hw_wr_en[i] ? hw_wr_data[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            for (int b = 0; b < STRB_W; b++)
                if (w_fire && wr_resp == RESP_OKAY && wr_idx == ADDR_WIDTH'(i) && s_wstrb[b])
                    regs_d[i][8*b +: 8] = s_wdata[8*b +: 8];
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++)
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            awaddr_q <= '0;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            // NOTE: the register array is reset because software relies on all-zero contents.
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            awaddr_q <= awaddr_d;
            bresp_q  <= bresp_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            regs_q   <= regs_d;
        end
    end

endmodule
